region_cic_arbiter: RTL and testbench
=====================================

Name: region_cic_arbiter

Overview:
Parametrised region-detection arbiter for the switchless mod. It takes status from NUM_REGIONS parallel lockout-key instances, each seeded for one region, and generates their shared clock-enable. It resolves the cartridge region from which keys stay alive, qualifies it with a settle window, and drives host reset, start and a timed region-override window. The block sits between the per-region key instances and the console region/reset pins.

Parameters:
NUM_REGIONS, 2, number of key instances/regions; legal range 2..8
REGION_W, $clog2(NUM_REGIONS), width of region index; derived, not overridable
PRESCALE_DIV, 4, key clock-enable period in clk cycles; minimum 2
SETTLE_TICKS, 1024, clk cycles the dead vector must be stable before region lock
TIMEOUT_TICKS, 36_000_000, override window length in clk cycles; about 9 s at 4 MHz
CNT_W, 32, width of the timeout and settle counters

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
key_start  in  NUM_REGIONS  per-key start flag
key_dead  in  NUM_REGIONS  per-key dead flag; 1 = key has rejected the cartridge
key_rst_host  in  NUM_REGIONS  per-key host-reset request
key_clk_en  out  1  one-cycle pulse every PRESCALE_DIV clocks; clocks all keys
start  out  1  registered copy of key_start[0]
rst_host  out  1  registered OR of key_rst_host
cartridge_region  out  REGION_W  resolved region index
region_valid  out  1  1 while in LOCKED
region_fault  out  1  1 while in FAULT; no key alive
region_override  out  1  1 while the timeout counter is nonzero

Behaviour:
- Reset (rst=0, asynchronous) forces all outputs to 0, the prescaler to 0, the timeout counter to 0 and the FSM to PROBE.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1.
  - key_clk_en=1 in the cycle where the count equals PRESCALE_DIV-1; first pulse is PRESCALE_DIV cycles after reset release.
- start and rst_host: registered, 1-cycle latency from their inputs.
- Timeout counter:
  - Loads TIMEOUT_TICKS in any cycle where registered rst_host=1.
  - Otherwise decrements while nonzero and saturates at 0.
  - region_override = (counter != 0); it is 0 after reset until the first rst_host.
- FSM states and transitions:
  - PROBE:
    - The settle counter clears whenever key_dead differs from its previous-cycle value.
    - When the settle counter reaches SETTLE_TICKS: go to FAULT if key_dead is all-ones, else go to LOCKED.
    - On entering LOCKED, latch cartridge_region = index of the lowest-indexed 0 bit of key_dead.
  - LOCKED:
    - cartridge_region is held.
    - Go to PROBE if the latched channel's key_dead rises.
    - Go to PROBE in the cycle registered rst_host rises; see the optional feature.
  - FAULT:
    - cartridge_region holds its last value (0 if never locked).
    - Go to PROBE when any key_dead bit falls or registered rst_host rises.
- Tie-break: if several keys are alive, the lowest index wins. Region mismatch does not raise fault.
- Simultaneous events:
  - A registered rst_host rise in the same cycle as a dead change goes to PROBE once.
  - The timeout reload has priority over the decrement.
- region_valid and region_fault update in the same cycle as the state register; they are never both 1.

Optional Feature:
REGION_STICKY_EN
- Defined: once LOCKED has been reached, a registered rst_host rise does not leave LOCKED. Only a rise of the latched channel's key_dead, or reset, re-probes. This avoids region flicker on console reset.
- Undefined: a registered rst_host rise always returns to PROBE, as stated in Behaviour.

Decomposition:
- Package region_cic_pkg holds:
  - state enum: PROBE=2'd0, LOCKED=2'd1, FAULT=2'd2
  - a lowest-zero-index function, parametrised by width
- Sub-module region_prescaler (parameter DIV, outputs clk_en) replaces the fixed divide-by-4 prescaler. The FSM, counters and output registers stay in the top.

Test Plan:
All scenarios use NUM_REGIONS=3, PRESCALE_DIV=4, SETTLE_TICKS=4, TIMEOUT_TICKS=20.
- Reset release, key_dead=3'b110 held: key_clk_en pulses at cycles 4, 8, 12…; region_valid=1 and cartridge_region=0 five cycles after the first sampled value.
- key_dead toggles 3'b101 then 3'b011 every 2 cycles: region_valid stays 0 throughout. Hold 3'b011: after 4 stable cycles, cartridge_region=2 and region_valid=1.
- key_dead=3'b111 stable: region_fault=1, region_valid=0. Then drop bit1 (3'b101): PROBE, then LOCKED with cartridge_region=1.
- key_rst_host[2] pulsed 1 cycle: rst_host high 1 cycle later; region_override=1 for exactly 20 cycles after rst_host falls. A second pulse mid-window reloads the counter to 20.
- In LOCKED (region 0), pulse rst_host: FSM returns to PROBE (REGION_STICKY_EN off). With REGION_STICKY_EN, region_valid stays 1 with no gap.
- Assert rst=0 mid-settle and mid-override: all outputs are 0 immediately, without waiting for a clk edge; the prescaler restarts from 0 on release.

Source files
------------

// File: rtl/region_cic_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// region_cic_pkg
// Shared types and helpers for the region-detection arbiter.
//   state_t     : arbiter FSM states (PROBE / LOCKED / FAULT)
//   lowest_zero : index of the lowest 0 bit among the low `width` bits of vec
// ----------------------------------------------------------------------------
package region_cic_pkg;

    localparam int unsigned MAX_REGIONS = 8;
    localparam int unsigned MAX_IDX_W   = 3;

    typedef enum logic [1:0] {
        PROBE  = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Bits at or above `width` are ignored. Returns 0 when no bit is clear.
    // Scans downwards so the lowest clear index is the one left standing.
    function automatic logic [MAX_IDX_W-1:0] lowest_zero(
        input logic [MAX_REGIONS-1:0] vec,
        input int unsigned            width
    );
        lowest_zero = '0;
        for (int unsigned i = MAX_REGIONS; i > 0; i--) begin
            if ((i - 1) < width && !vec[i-1]) begin
                lowest_zero = MAX_IDX_W'(i - 1);
            end
        end
    endfunction

endpackage

// File: rtl/region_cic_arbiter_if.sv
// ----------------------------------------------------------------------------
// region_cic_arbiter_if
// Bundle between the per-region lockout-key instances and the arbiter.
//   key_start, key_dead, key_rst_host : per-key status (NUM_REGIONS wide)
//   key_clk_en       : shared key clock-enable pulse
//   start, rst_host  : registered host start / host reset
//   cartridge_region : resolved region index (REGION_W wide)
//   region_valid, region_fault, region_override : arbiter status
// Modports: master = key/console side, slave = arbiter.
// ----------------------------------------------------------------------------
interface region_cic_arbiter_if #(
    parameter int unsigned NUM_REGIONS = 2
);
    import region_cic_pkg::*;

    localparam int unsigned REGION_W = $clog2(NUM_REGIONS);

    logic [NUM_REGIONS-1:0] key_start;
    logic [NUM_REGIONS-1:0] key_dead;
    logic [NUM_REGIONS-1:0] key_rst_host;
    logic                   key_clk_en;
    logic                   start;
    logic                   rst_host;
    logic [REGION_W-1:0]    cartridge_region;
    logic                   region_valid;
    logic                   region_fault;
    logic                   region_override;

    modport master (
        output key_start, key_dead, key_rst_host,
        input  key_clk_en, start, rst_host, cartridge_region,
               region_valid, region_fault, region_override
    );

    modport slave (
        input  key_start, key_dead, key_rst_host,
        output key_clk_en, start, rst_host, cartridge_region,
               region_valid, region_fault, region_override
    );

endinterface

// File: rtl/region_cic_arbiter_prescaler.sv
// ----------------------------------------------------------------------------
// region_prescaler
// Free-running divide-by-DIV counter producing the key clock-enable.
//   clk    : system clock
//   rst    : asynchronous active-low reset
//   clk_en : high for one cycle whenever the count sits at DIV-1
// ----------------------------------------------------------------------------
module region_prescaler
    import region_cic_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic clk_en
);
    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Decoded from the count so the enable drops with reset immediately.
    assign clk_en = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/region_cic_arbiter.sv
// ----------------------------------------------------------------------------
// region_cic_arbiter
// Resolves the cartridge region from which lockout keys stay alive, qualifies
// it with a settle window, and drives host reset/start plus a timed
// region-override window.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : region_cic_arbiter_if.slave (key status in, arbiter status out)
// Build option: define REGION_STICKY_EN to keep LOCKED across host resets.
// ----------------------------------------------------------------------------
module region_cic_arbiter
    import region_cic_pkg::*;
#(
    parameter int unsigned NUM_REGIONS   = 2,
    parameter int unsigned PRESCALE_DIV  = 4,
    parameter int unsigned SETTLE_TICKS  = 1024,
    parameter int unsigned TIMEOUT_TICKS = 36_000_000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    region_cic_arbiter_if.slave  bus
);
    localparam int unsigned REGION_W = $clog2(NUM_REGIONS);

    state_t                 state, state_next;
    logic [NUM_REGIONS-1:0] dead_prev;
    logic [CNT_W-1:0]       settle_cnt;
    logic [CNT_W-1:0]       timeout_cnt;
    logic                   start_q;
    logic                   rst_host_q;
    logic                   rst_host_d;
    logic [REGION_W-1:0]    region_q;

    logic                   dead_changed;
    logic                   dead_fell;
    logic                   latched_rose;
    logic                   host_rose;
    logic                   settle_done;
    logic                   lock_load;
    logic [REGION_W-1:0]    lock_region;
    logic                   unused_start;

    region_prescaler #(.DIV(PRESCALE_DIV)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clk_en (bus.key_clk_en)
    );

    assign dead_changed = (bus.key_dead != dead_prev);
    assign dead_fell    = |(dead_prev & ~bus.key_dead);
    assign latched_rose = bus.key_dead[region_q] & ~dead_prev[region_q];
    assign host_rose    = rst_host_q & ~rst_host_d;
    assign settle_done  = (settle_cnt == CNT_W'(SETTLE_TICKS));
    assign lock_region  = REGION_W'(lowest_zero(MAX_REGIONS'(bus.key_dead), NUM_REGIONS));
    assign unused_start = ^bus.key_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PROBE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        lock_load  = 1'b0;
        case (state)
            PROBE: begin
                // Require the current sample to match as well, so a change
                // landing on the final settle cycle never gets latched.
                if (settle_done && !dead_changed) begin
                    if (&bus.key_dead) begin
                        state_next = FAULT;
                    end else begin
                        state_next = LOCKED;
                        lock_load  = 1'b1;
                    end
                end
            end
            LOCKED: begin
`ifdef REGION_STICKY_EN
                if (latched_rose) begin
                    state_next = PROBE;
                end
`else
                if (latched_rose || host_rose) begin
                    state_next = PROBE;
                end
`endif
            end
            FAULT: begin
                if (dead_fell || host_rose) begin
                    state_next = PROBE;
                end
            end
            default: state_next = PROBE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dead_prev   <= '0;
            settle_cnt  <= '0;
            timeout_cnt <= '0;
            start_q     <= 1'b0;
            rst_host_q  <= 1'b0;
            rst_host_d  <= 1'b0;
            region_q    <= '0;
        end else begin
            dead_prev  <= bus.key_dead;
            start_q    <= bus.key_start[0];
            rst_host_q <= |bus.key_rst_host;
            rst_host_d <= rst_host_q;

            if (rst_host_q) begin
                timeout_cnt <= CNT_W'(TIMEOUT_TICKS);
            end else if (timeout_cnt != '0) begin
                timeout_cnt <= timeout_cnt - 1'b1;
            end

            // Settle count only runs in PROBE; it saturates at the threshold.
            if (state != PROBE || dead_changed) begin
                settle_cnt <= '0;
            end else if (!settle_done) begin
                settle_cnt <= settle_cnt + 1'b1;
            end

            if (lock_load) begin
                region_q <= lock_region;
            end
        end
    end

    assign bus.start            = start_q;
    assign bus.rst_host         = rst_host_q;
    assign bus.cartridge_region = region_q;
    assign bus.region_valid     = (state == LOCKED);
    assign bus.region_fault     = (state == FAULT);
    assign bus.region_override  = (timeout_cnt != '0);

endmodule

// File: tb/tb_region_cic_arbiter.sv
// ----------------------------------------------------------------------------
// tb_region_cic_arbiter
// Self-checking bench for region_cic_arbiter (3 regions, divide-by-4,
// settle 4, timeout 20) with a behavioural model of the arbiter rules.
// Honours REGION_STICKY_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_region_cic_arbiter;

    localparam int unsigned NR      = 3;
    localparam int unsigned DIV     = 4;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 20;
`ifdef REGION_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] key_start = '0;
    logic [NR-1:0] key_dead = '0;
    logic [NR-1:0] key_rst_host = '0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    region_cic_arbiter_if #(.NUM_REGIONS(NR)) bus ();

    assign bus.key_start    = key_start;
    assign bus.key_dead     = key_dead;
    assign bus.key_rst_host = key_rst_host;

    region_cic_arbiter #(
        .NUM_REGIONS   (NR),
        .PRESCALE_DIV  (DIV),
        .SETTLE_TICKS  (SETTLE),
        .TIMEOUT_TICKS (TIMEOUT),
        .CNT_W         (32)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned   m_edges;
    int unsigned   m_ovr;
    int unsigned   m_run;
    int unsigned   m_region;
    bit            m_start, m_host, m_host_prev, m_locked, m_fault;
    logic [NR-1:0] m_prev_dead;

    task automatic model_reset();
        m_edges = 0; m_ovr = 0; m_run = 0; m_region = 0;
        m_start = 0; m_host = 0; m_host_prev = 0; m_locked = 0; m_fault = 0;
        m_prev_dead = '0;
    endtask

    function automatic int unsigned first_alive(input logic [NR-1:0] d);
        first_alive = 0;
        for (int i = NR - 1; i >= 0; i--) begin
            if (!d[i]) first_alive = i;
        end
    endfunction

    task automatic model_step();
        logic [NR-1:0] d = key_dead;
        bit host_rise = m_host && !m_host_prev;
        bit probing   = !m_locked && !m_fault;
        bit lock      = m_locked;
        bit flt       = m_fault;
        if (probing) begin
            if (m_run == SETTLE && d == m_prev_dead) begin
                if (d == {NR{1'b1}}) flt = 1;
                else begin
                    lock = 1;
                    m_region = first_alive(d);
                end
            end
        end else if (m_locked) begin
            if ((d[m_region] && !m_prev_dead[m_region]) || (!STICKY && host_rise)) lock = 0;
        end else begin
            if ((m_prev_dead & ~d) != '0 || host_rise) flt = 0;
        end
        if (!probing || d != m_prev_dead) m_run = 0;
        else if (m_run < SETTLE) m_run++;
        m_ovr = m_host ? TIMEOUT : ((m_ovr > 0) ? m_ovr - 1 : 0);
        m_host_prev = m_host;
        m_host = |key_rst_host;
        m_start = key_start[0];
        m_prev_dead = d;
        m_locked = lock;
        m_fault = flt;
        m_edges++;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        else n_pass++;
    endtask

    task automatic compare_all();
        check("clk_en",   32'(bus.key_clk_en),       32'((m_edges % DIV) == DIV - 1));
        check("start",    32'(bus.start),            32'(m_start));
        check("rst_host", 32'(bus.rst_host),         32'(m_host));
        check("region",   32'(bus.cartridge_region), m_region);
        check("valid",    32'(bus.region_valid),     32'(m_locked));
        check("fault",    32'(bus.region_fault),     32'(m_fault));
        check("override", 32'(bus.region_override),  32'(m_ovr != 0));
    endtask

    task automatic check_zero(input string tag);
        logic [31:0] all = 32'({bus.key_clk_en, bus.start, bus.rst_host, bus.cartridge_region,
                                bus.region_valid, bus.region_fault, bus.region_override});
        check(tag, all, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_host(input logic [NR-1:0] bits);
        key_rst_host = bits;
        tick();
        key_rst_host = '0;
        tick();
    endtask

    task automatic measure_window(input string tag);
        int unsigned w = 0;
        while (bus.region_override && w < 100) begin
            w++;
            tick();
        end
        check(tag, w, TIMEOUT);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned vmin;

        // power-on reset with 110 already presented
        key_dead = 3'b110;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;

        // T1: region 0 locks five cycles after the first sample
        tick(); check("t1_clk_en_e1", 32'(bus.key_clk_en), 0);
        tick();
        tick(); check("t1_clk_en_e3", 32'(bus.key_clk_en), 1);
        ticks(2); check("t1_valid_early", 32'(bus.region_valid), 0);
        tick();
        check("t1_valid", 32'(bus.region_valid), 1);
        check("t1_region", 32'(bus.cartridge_region), 0);

        // T2: toggling dead vector never settles; then 011 settles to region 2
        vmin = 0;
        for (int i = 0; i < 6; i++) begin
            key_dead = (i % 2 == 0) ? 3'b101 : 3'b011;
            ticks(2);
            vmin = vmin | 32'(bus.region_valid);
        end
        check("t2_no_valid_toggling", vmin, 0);
        key_dead = 3'b011;
        ticks(8);
        check("t2_valid", 32'(bus.region_valid), 1);
        check("t2_region", 32'(bus.cartridge_region), 2);

        // T3: all dead -> fault; drop bit1 -> relock on region 1
        key_dead = 3'b111;
        ticks(8);
        check("t3_fault", 32'(bus.region_fault), 1);
        check("t3_not_valid", 32'(bus.region_valid), 0);
        key_dead = 3'b101;
        ticks(8);
        check("t3_valid", 32'(bus.region_valid), 1);
        check("t3_region", 32'(bus.cartridge_region), 1);

        // T4: override window length and reload
        key_rst_host = 3'b100;
        tick();
        check("t4_rst_host_hi", 32'(bus.rst_host), 1);
        key_rst_host = '0;
        tick();
        check("t4_rst_host_lo", 32'(bus.rst_host), 0);
        measure_window("t4_window");
        pulse_host(3'b100);
        ticks(8);
        pulse_host(3'b100);
        measure_window("t4_reload_window");

        // T5: host reset while locked on region 0
        key_dead = 3'b110;
        ticks(12);
        check("t5_locked", 32'(bus.region_valid), 1);
        vmin = 1;
        key_rst_host = 3'b001; tick(); vmin = vmin & 32'(bus.region_valid);
        key_rst_host = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vmin = vmin & 32'(bus.region_valid);
        end
        check("t5_valid_min", vmin, 32'(STICKY));

        // T6: async reset mid-settle and mid-override
        pulse_host(3'b010);
        key_dead = 3'b011;
        ticks(2);
        #2 rst_n = 1'b0;
        #1 check_zero("t6_async_zero");
        @(posedge clk);
        @(posedge clk);
        #1 check_zero("t6_held_zero");
        rst_n = 1'b1;
        model_reset();
        tick(); check("t6_clk_en_e1", 32'(bus.key_clk_en), 0);
        tick(); check("t6_clk_en_e2", 32'(bus.key_clk_en), 0);
        tick(); check("t6_clk_en_e3", 32'(bus.key_clk_en), 1);

        // Random phase
        for (int it = 0; it < 150; it++) begin
            int unsigned hold;
            key_dead = NR'($urandom_range(0, 7));
            hold = $urandom_range(1, 12);
            for (int unsigned c = 0; c < hold; c++) begin
                key_start = NR'($urandom);
                key_rst_host = ($urandom_range(0, 15) == 0) ? NR'($urandom_range(1, 7)) : '0;
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
